// File: rtl/phase_accumulator.sv
// Phase accumulator (NCO core) for the PLL frequency-generation path.
// Adds the active frequency control word to the phase register on each
// enabled cycle; the carry-out is registered as a one-cycle wrap pulse and
// toggles tick_out. A new word accepted over fcw_valid/fcw_ready is held
// pending and swapped in only on a wrap edge so the waveform stays glitch-free.
// Optional: define PHASE_ACC_WRAP_CNT_EN to add the 8-bit wrap_cnt output.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no word loaded yet; phase held at 0, en ignored
//   RUN     | accumulating with fcw_active, ready for a retune word
//   PENDING | accumulating, retune word held in fcw_pend until next wrap
module phase_accumulator #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            sync_clr,
  input  logic [SIZE-1:0] fcw,
  input  logic            fcw_valid,
  output logic            fcw_ready,
  output logic [SIZE-1:0] phase,
  output logic            wrap,
  output logic            tick_out,
  output logic            active
`ifdef PHASE_ACC_WRAP_CNT_EN
  ,
  output logic [7:0]      wrap_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [SIZE-1:0] fcw_active, fcw_active_nxt;
  logic [SIZE-1:0] fcw_pend, fcw_pend_nxt;
  logic [SIZE-1:0] phase_nxt;
  logic            wrap_nxt;
  logic            tick_nxt;
  logic            handshake;
  logic [SIZE:0]   sum;

  // A retune word can only be parked while no other word is waiting.
  assign fcw_ready = (state != PENDING);
  assign handshake = fcw_valid && fcw_ready;
  assign sum       = {1'b0, phase} + {1'b0, fcw_active};

  // Next-state and datapath decode; sync_clr overrides en and any handshake.
  always_comb begin
    state_nxt      = state;
    fcw_active_nxt = fcw_active;
    fcw_pend_nxt   = fcw_pend;
    phase_nxt      = phase;
    wrap_nxt       = 1'b0;
    tick_nxt       = tick_out;
    if (sync_clr) begin
      phase_nxt = '0;
      tick_nxt  = 1'b0;
      if (state == PENDING) begin
        fcw_active_nxt = fcw_pend;
        state_nxt      = RUN;
      end
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            fcw_active_nxt = fcw;
            state_nxt      = RUN;
          end
        end
        RUN: begin
          if (en) begin
            phase_nxt = sum[SIZE-1:0];
            wrap_nxt  = sum[SIZE];
            tick_nxt  = tick_out ^ sum[SIZE];
          end
          if (handshake) begin
            fcw_pend_nxt = fcw;
            state_nxt    = PENDING;
          end
        end
        PENDING: begin
          if (en) begin
            phase_nxt = sum[SIZE-1:0];
            wrap_nxt  = sum[SIZE];
            tick_nxt  = tick_out ^ sum[SIZE];
          end
          // A zero word can never wrap, so the pending word is taken at once.
          if ((fcw_active == '0) || (en && sum[SIZE])) begin
            fcw_active_nxt = fcw_pend;
            state_nxt      = RUN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fcw_active <= '0;
      fcw_pend   <= '0;
      phase      <= '0;
      wrap       <= 1'b0;
      tick_out   <= 1'b0;
      active     <= 1'b0;
    end else begin
      state      <= state_nxt;
      fcw_active <= fcw_active_nxt;
      fcw_pend   <= fcw_pend_nxt;
      phase      <= phase_nxt;
      wrap       <= wrap_nxt;
      tick_out   <= tick_nxt;
      active     <= (state_nxt != IDLE);
    end
  end

`ifdef PHASE_ACC_WRAP_CNT_EN
  // Free-running count of wrap pulses, advanced on the edge that sets wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_cnt <= 8'd0;
    end else if (sync_clr) begin
      wrap_cnt <= 8'd0;
    end else if (wrap_nxt) begin
      wrap_cnt <= wrap_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_phase_accumulator.sv
// Randomized bench for phase_accumulator (SIZE=4) against a behavioural model.
module tb_phase_accumulator;

  localparam int SIZE = 4;
  localparam int MOD  = 1 << SIZE;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            sync_clr = 1'b0;
  logic [SIZE-1:0] fcw = '0;
  logic            fcw_valid = 1'b0;
  logic            fcw_ready;
  logic [SIZE-1:0] phase;
  logic            wrap;
  logic            tick_out;
  logic            active;
`ifdef PHASE_ACC_WRAP_CNT_EN
  logic [7:0]      wrap_cnt;
`endif

  phase_accumulator #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sync_clr  (sync_clr),
    .fcw       (fcw),
    .fcw_valid (fcw_valid),
    .fcw_ready (fcw_ready),
    .phase     (phase),
    .wrap      (wrap),
    .tick_out  (tick_out),
    .active    (active)
`ifdef PHASE_ACC_WRAP_CNT_EN
    ,
    .wrap_cnt  (wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: a loaded word, an optional parked word, a phase number.
  bit m_loaded, m_pend;
  int m_word, m_pword, m_acc, m_wrap, m_tick, m_cnt;
  bit offer_waiting;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loaded = 0; m_pend = 0; m_word = 0; m_pword = 0;
    m_acc = 0; m_wrap = 0; m_tick = 0; m_cnt = 0;
    offer_waiting = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".phase"}, int'(phase), m_acc);
    chk({tag, ".wrap"}, int'(wrap), m_wrap);
    chk({tag, ".tick"}, int'(tick_out), m_tick);
    chk({tag, ".active"}, int'(active), int'(m_loaded));
    chk({tag, ".ready"}, int'(fcw_ready), int'(!m_pend));
`ifdef PHASE_ACC_WRAP_CNT_EN
    chk({tag, ".wrap_cnt"}, int'(wrap_cnt), m_cnt);
`endif
  endtask

  // One clock: drive inputs, predict the edge, check after it.
  task automatic cycle(input bit en_i, input bit clr_i, input bit val_i, input int f_i);
    bit hs, took_word;
    int s;
    en = en_i; sync_clr = clr_i; fcw_valid = val_i; fcw = SIZE'(f_i);
    #1;
    chk("ready_comb", int'(fcw_ready), int'(!m_pend));
    hs = val_i && !m_pend;
    took_word = 0;
    if (clr_i) begin
      m_acc = 0; m_wrap = 0; m_tick = 0; m_cnt = 0;
      if (m_pend) begin m_word = m_pword; m_pend = 0; end
    end else if (!m_loaded) begin
      m_wrap = 0;
      if (hs) begin m_word = f_i; m_loaded = 1; took_word = 1; end
    end else begin
      m_wrap = 0;
      if (en_i) begin
        s = m_acc + m_word;
        m_acc = s % MOD;
        if (s >= MOD) begin
          m_wrap = 1; m_tick ^= 1; m_cnt = (m_cnt + 1) % 256;
        end
      end
      if (m_pend) begin
        if (m_word == 0 || m_wrap == 1) begin m_word = m_pword; m_pend = 0; end
      end else if (hs) begin
        m_pword = f_i; m_pend = 1; took_word = 1;
      end
    end
    offer_waiting = val_i && !took_word;
    @(posedge clk);
    #1;
    check_outputs("edge");
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    fcw_valid = 1'b0;
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("post_rst");
  endtask

  int exp_ph[6] = '{3, 6, 9, 12, 15, 2};

  initial begin
    int f;
    bit v, e, c;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: fcw=3, six enabled adds; wrap only on the 15->2 add.
    cycle(1, 0, 1, 3);
    chk("dir.active_after_hs", int'(active), 1);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 0, 0);
      chk("dir.phase", int'(phase), exp_ph[i]);
      chk("dir.wrap", int'(wrap), (i == 5) ? 1 : 0);
    end
    chk("dir.tick", int'(tick_out), 1);

    // Directed: zero word, then retune to 6 without a wrap.
    async_reset();
    cycle(1, 0, 1, 0);
    cycle(1, 0, 0, 0);
    chk("zero.phase", int'(phase), 0);
    cycle(1, 0, 1, 6);
    chk("zero.ready", int'(fcw_ready), 0);
    cycle(1, 0, 0, 0);
    chk("zero.ready_back", int'(fcw_ready), 1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("zero.phase_wrap", int'(phase), 2);
    chk("zero.wrap", int'(wrap), 1);

    // Random traffic with occasional async resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) async_reset();
      e = ($urandom_range(0, 7) != 0);
      c = ($urandom_range(0, 31) == 0);
      if (offer_waiting) begin
        v = 1; f = int'(fcw);
      end else begin
        v = ($urandom_range(0, 5) == 0);
        f = (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, MOD - 1)));
      end
      cycle(e, c, v, f);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
